// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_N        = 8;
    localparam int unsigned ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping at N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N     = ARB_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner_c,
    output logic             any_req_c
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] enc;
    logic             found;

    // Rotate right by ptr so the highest-priority requester lands in bit 0.
    always_comb begin
        rot = '0;
        src = '0;
        for (int i = 0; i < int'(N); i++) begin
            src    = IDX_W'(i) + ptr;
            rot[i] = req[src];
        end
    end

    always_comb begin
        enc   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (rot[i] && !found) begin
                enc   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    // N is a power of two, so the IDX_W-bit sum wraps modulo N for free.
    assign winner_c  = enc + ptr;
    assign any_req_c = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters and holds it until done.
// Optional forced release after MAX_HOLD busy cycles under ARB_TIMEOUT_EN.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N        = ARB_N,
    parameter  int unsigned MAX_HOLD = ARB_MAX_HOLD,
    localparam int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("rr_arbiter: N must be a power of two >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_t       state;
    arb_state_t       state_d;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             busy_d;
    logic             timeout_d;
    logic [IDX_W-1:0] win_c;
    logic             any_req_c;
    logic             expire_c;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .winner_c  (win_c),
        .any_req_c (any_req_c)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt;

    // Counts busy cycles of the current grant; idle keeps it cleared for the next entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign expire_c = (state == ARB_BUSY) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign expire_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ARB_IDLE: if (any_req_c)        state_d = ARB_BUSY;
            ARB_BUSY: if (done || expire_c) state_d = ARB_IDLE;
            default:                        state_d = ARB_IDLE;
        endcase
    end

    // Next values for the registered outputs and the priority pointer.
    always_comb begin
        gnt_d     = gnt;
        idx_d     = gnt_idx;
        busy_d    = busy;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        case (state)
            ARB_IDLE: begin
                if (any_req_c) begin
                    gnt_d  = N'(1) << win_c;
                    idx_d  = win_c;
                    busy_d = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (done || expire_c) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = !done;
                    ptr_d     = gnt_idx + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
        end else begin
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            busy    <= busy_d;
            timeout <= timeout_d;
            ptr     <= ptr_d;
        end
    end

endmodule
